// File: rtl/truth_table_engine.sv
// ============================================================================
//  Module      : truth_table_engine
//  Description : Programmable truth table with registered lookup and a
//                valid/ready sweep that streams every row in index order.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_engine #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [N_IN-1:0]  wr_addr,
   input  logic [N_OUT-1:0] wr_data,
   output logic             wr_err,
   input  logic             eval_en,
   input  logic [N_IN-1:0]  eval_in,
   output logic [N_OUT-1:0] eval_out,
   output logic             eval_valid,
   input  logic             sweep_start,
   output logic             row_valid,
   input  logic             row_ready,
   output logic [N_IN-1:0]  row_idx,
   output logic [N_OUT-1:0] row_out,
   output logic             row_last,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam int              c_ROWS = 1 << N_IN;
   localparam logic [N_IN-1:0] c_LAST = '1;
   localparam logic [N_IN-1:0] c_ONE  = N_IN'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [N_IN-1:0]  r_cnt;
   logic [N_IN-1:0]  w_cnt_nxt;
   logic [N_OUT-1:0] r_table [c_ROWS];
   logic [N_OUT-1:0] r_eval_out;
   logic             r_eval_valid;
   logic             r_wr_err;
   logic             w_sweep;
   logic             w_xfer;
   logic             w_wr_ok;

   assign w_sweep = (r_state == S_SWEEP);
   assign w_xfer  = w_sweep && row_ready;
   assign w_wr_ok = wr_en && !w_sweep;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (sweep_start) begin
               w_state_nxt = S_SWEEP;
               w_cnt_nxt   = '0;
            end
         end
         S_SWEEP: begin
            if (w_xfer) begin
               if (r_cnt == c_LAST) begin
                  w_state_nxt = S_DONE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + c_ONE;
               end
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Writes are locked out during a sweep so the streamed rows stay coherent.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < c_ROWS; i++) begin
            r_table[i] <= '0;
         end
      end else if (w_wr_ok) begin
         r_table[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_eval_out   <= '0;
         r_eval_valid <= 1'b0;
         r_wr_err     <= 1'b0;
      end else begin
         r_eval_valid <= eval_en;
         r_wr_err     <= wr_en && w_sweep;
         if (eval_en) begin
            r_eval_out <= r_table[eval_in];
         end
      end
   end

   assign wr_err     = r_wr_err;
   assign eval_out   = r_eval_out;
   assign eval_valid = r_eval_valid;
   assign row_valid  = w_sweep;
   assign row_idx    = w_sweep ? r_cnt : '0;
   assign row_out    = w_sweep ? r_table[r_cnt] : '0;
   assign row_last   = w_sweep && (r_cnt == c_LAST);
   assign busy       = w_sweep;
   assign done       = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_truth_table_engine.sv
// ============================================================================
//  Module      : tb_truth_table_engine
//  Description : Scoreboard bench for truth_table_engine (4x6 and 2x3 builds).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_truth_table_engine;

   typedef struct packed {
      logic [3:0] idx;
      logic [5:0] data;
      logic       last;
   } row_t;

   typedef struct packed {
      logic [1:0] idx;
      logic [2:0] data;
      logic       last;
   } row2_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en, eval_en, sweep_start, row_ready;
   logic [3:0] wr_addr, eval_in;
   logic [5:0] wr_data;
   logic       wr_err, eval_valid, row_valid, row_last, busy, done;
   logic [5:0] eval_out, row_out;
   logic [3:0] row_idx;

   logic       s_wr_en, s_eval_en, s_sweep_start, s_row_ready;
   logic [1:0] s_wr_addr, s_eval_in, s_row_idx;
   logic [2:0] s_wr_data, s_eval_out, s_row_out;
   logic       s_wr_err, s_eval_valid, s_row_valid, s_row_last, s_busy, s_done;

   always #5 clk = ~clk;

   truth_table_engine #(.N_IN(4), .N_OUT(6)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_err(wr_err), .eval_en(eval_en), .eval_in(eval_in), .eval_out(eval_out),
      .eval_valid(eval_valid), .sweep_start(sweep_start), .row_valid(row_valid),
      .row_ready(row_ready), .row_idx(row_idx), .row_out(row_out),
      .row_last(row_last), .busy(busy), .done(done)
   );

   truth_table_engine #(.N_IN(2), .N_OUT(3)) dut2 (
      .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
      .wr_err(s_wr_err), .eval_en(s_eval_en), .eval_in(s_eval_in), .eval_out(s_eval_out),
      .eval_valid(s_eval_valid), .sweep_start(s_sweep_start), .row_valid(s_row_valid),
      .row_ready(s_row_ready), .row_idx(s_row_idx), .row_out(s_row_out),
      .row_last(s_row_last), .busy(s_busy), .done(s_done)
   );

   int         n_checks = 0;
   int         n_errors = 0;
   row_t       row_q[$];
   row2_t      row2_q[$];
   logic [5:0] eval_q[$];
   logic [5:0] model [16];
   logic [2:0] model2 [4];
   logic       exp_done = 1'b0;
   logic       exp_done2 = 1'b0;
   int         n_xfer = 0;
   int         n_xfer2 = 0;
   int         wr_err_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor for the 4-input build
   always @(negedge clk) begin
      row_t       r;
      logic [5:0] e;
      if (!rst) begin
         check("done", {31'd0, done}, {31'd0, exp_done});
         check("busy", {31'd0, busy}, {31'd0, row_q.size() != 0});
         exp_done = 1'b0;
         if (wr_err) wr_err_cnt++;
         if (eval_valid) begin
            if (eval_q.size() == 0) check("eval_spurious", 32'd1, 32'd0);
            else begin
               e = eval_q.pop_front();
               check("eval_out", {26'd0, eval_out}, {26'd0, e});
            end
         end
         if (row_valid) begin
            if (row_q.size() == 0) check("row_spurious", 32'd1, 32'd0);
            else begin
               r = row_q[0];
               check("row_idx", {28'd0, row_idx}, {28'd0, r.idx});
               check("row_out", {26'd0, row_out}, {26'd0, r.data});
               check("row_last", {31'd0, row_last}, {31'd0, r.last});
               if (row_ready) begin
                  row_q.delete(0);
                  n_xfer++;
                  exp_done = r.last;
               end
            end
         end
      end
   end

   // Scoreboard monitor for the 2-input build
   always @(negedge clk) begin
      row2_t r;
      if (!rst) begin
         check("done2", {31'd0, s_done}, {31'd0, exp_done2});
         exp_done2 = 1'b0;
         if (s_row_valid) begin
            if (row2_q.size() == 0) check("row2_spurious", 32'd1, 32'd0);
            else begin
               r = row2_q[0];
               check("row2_idx", {30'd0, s_row_idx}, {30'd0, r.idx});
               check("row2_out", {29'd0, s_row_out}, {29'd0, r.data});
               check("row2_last", {31'd0, s_row_last}, {31'd0, r.last});
               if (s_row_ready) begin
                  row2_q.delete(0);
                  n_xfer2++;
                  exp_done2 = r.last;
               end
            end
         end
      end
   end

   task automatic do_write(input logic [3:0] a, input logic [5:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d; model[a] = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic do_eval(input logic [3:0] a, input logic [5:0] e);
      eval_en = 1'b1; eval_in = a; eval_q.push_back(e);
      @(posedge clk); #1;
      eval_en = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_row_valid"}, {31'd0, row_valid}, 32'd0);
      check({tag, "_row_idx"}, {28'd0, row_idx}, 32'd0);
      check({tag, "_row_out"}, {26'd0, row_out}, 32'd0);
      check({tag, "_row_last"}, {31'd0, row_last}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
      check({tag, "_wr_err"}, {31'd0, wr_err}, 32'd0);
      check({tag, "_eval_valid"}, {31'd0, eval_valid}, 32'd0);
      check({tag, "_eval_out"}, {26'd0, eval_out}, 32'd0);
   endtask

   // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating
   task automatic run_sweep(input int mode, input bit hold_start, input int wr_at, input int rst_at);
      row_t r;
      int   k;
      bit   wr_done;
      @(posedge clk); #1;
      sweep_start = 1'b1;
      @(posedge clk); #1;
      n_xfer = 0;
      for (int i = 0; i < 16; i++) begin
         r.idx = 4'(i); r.data = model[i]; r.last = (i == 15);
         row_q.push_back(r);
      end
      if (!hold_start) sweep_start = 1'b0;
      k = 0; wr_done = 1'b0;
      row_ready = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(posedge clk); #1;
         wr_en = 1'b0;
         if (row_q.size() == 0) break;
         if (wr_at >= 0 && !wr_done && int'(row_q[0].idx) == wr_at) begin
            wr_en = 1'b1; wr_addr = 4'(wr_at); wr_data = ~model[wr_at]; wr_done = 1'b1;
         end
         if (rst_at >= 0 && int'(row_q[0].idx) == rst_at) begin
            rst = 1'b1;
            #1;
            check_all_zero("mid_reset");
            row_q.delete();
            for (int i = 0; i < 16; i++) model[i] = '0;
            sweep_start = 1'b0; row_ready = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            return;
         end
         k++;
         row_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      end
      check("sweep_complete", row_q.size(), 32'd0);
      check("n_xfer", n_xfer, 32'd16);
      if (hold_start) begin
         @(posedge clk); #1;
         sweep_start = 1'b0;
      end
      row_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic run_sweep2();
      row2_t r;
      @(posedge clk); #1;
      s_sweep_start = 1'b1;
      @(posedge clk); #1;
      s_sweep_start = 1'b0;
      n_xfer2 = 0;
      for (int i = 0; i < 4; i++) begin
         r.idx = 2'(i); r.data = model2[i]; r.last = (i == 3);
         row2_q.push_back(r);
      end
      s_row_ready = 1'b1;
      for (int t = 0; t < 50; t++) begin
         @(posedge clk); #1;
         if (row2_q.size() == 0) break;
      end
      check("sweep2_complete", row2_q.size(), 32'd0);
      check("n_xfer2", n_xfer2, 32'd4);
      s_row_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int wr_err_before;
      rst = 1'b1;
      wr_en = 0; eval_en = 0; sweep_start = 0; row_ready = 0;
      wr_addr = 0; wr_data = 0; eval_in = 0;
      s_wr_en = 0; s_eval_en = 0; s_sweep_start = 0; s_row_ready = 0;
      s_wr_addr = 0; s_wr_data = 0; s_eval_in = 0;
      for (int i = 0; i < 16; i++) model[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      check("reset2_row_valid", {31'd0, s_row_valid}, 32'd0);
      rst = 1'b0;

      // Immediate sweep after reset, sweep_start held through SWEEP and DONE
      run_sweep(0, 1'b1, -1, -1);

      // Writes and consecutive evals
      do_write(4'd5, 6'b101101);
      do_write(4'd10, 6'b010011);
      do_eval(4'd5, 6'b101101);
      do_eval(4'd10, 6'b010011);
      do_eval(4'd3, 6'b000000);
      // Same-cycle eval and write returns the old contents
      do_write(4'd12, 6'h2A);
      eval_en = 1'b1; eval_in = 4'd12; eval_q.push_back(6'h2A);
      do_write(4'd12, 6'h15);
      eval_en = 1'b0;
      do_eval(4'd12, 6'h15);
      repeat (3) @(posedge clk);
      #1;
      check("eval_hold_out", {26'd0, eval_out}, 32'h15);
      check("eval_hold_valid", {31'd0, eval_valid}, 32'd0);

      // Stalling consumer
      do_write(4'd0, 6'h3F);
      do_write(4'd15, 6'h11);
      run_sweep(1, 1'b0, -1, -1);

      // Rejected write during sweep
      do_write(4'd7, 6'h07);
      wr_err_before = wr_err_cnt;
      run_sweep(0, 1'b0, 7, -1);
      check("wr_err_pulses", wr_err_cnt - wr_err_before, 32'd1);
      do_eval(4'd7, 6'h07);

      // Reset in the middle of a sweep
      do_write(4'd9, 6'h21);
      do_eval(4'd5, 6'b101101);
      run_sweep(0, 1'b0, -1, 9);
      repeat (3) @(posedge clk);
      #1;
      do_eval(4'd5, 6'h00);
      do_eval(4'd9, 6'h00);
      do_eval(4'd10, 6'h00);
      run_sweep(0, 1'b0, -1, -1);

      // Small build: program all rows and sweep twice to show the wrap to 0
      model2[0] = 3'b101; model2[1] = 3'b010; model2[2] = 3'b111; model2[3] = 3'b001;
      for (int i = 0; i < 4; i++) begin
         s_wr_en = 1'b1; s_wr_addr = 2'(i); s_wr_data = model2[i];
         @(posedge clk); #1;
      end
      s_wr_en = 1'b0;
      run_sweep2();
      run_sweep2();

      repeat (3) @(posedge clk);
      #1;
      check("eval_q_drained", eval_q.size(), 32'd0);
      check("row_q_drained", row_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire

// File: doc/truth_table_engine.md
TRUTH_TABLE_ENGINE -- requirements
Module: truth_table_engine

Interface
REQ-001 Parameter N_IN, default 4: number of function inputs; legal range 2..6.
REQ-002 Parameter N_OUT, default 6: number of function outputs per row; legal range 1..16.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 wr_en  in  1  program one truth-table row this cycle.
REQ-006 wr_addr  in  N_IN  row index being programmed.
REQ-007 wr_data  in  N_OUT  output bits for that row.
REQ-008 wr_err  out  1  one-cycle pulse: write rejected because a sweep is active.
REQ-009 eval_en  in  1  request lookup of eval_in.
REQ-010 eval_in  in  N_IN  input combination to evaluate.
REQ-011 eval_out  out  N_OUT  registered lookup result.
REQ-012 eval_valid  out  1  eval_out is valid this cycle.
REQ-013 sweep_start  in  1  begin streaming every row 0..2^N_IN-1.
REQ-014 row_valid  out  1  row_idx/row_out/row_last are valid.
REQ-015 row_ready  in  1  consumer accepts the current row.
REQ-016 row_idx  out  N_IN  index of the streamed row.
REQ-017 row_out  out  N_OUT  table contents at row_idx.
REQ-018 row_last  out  1  high with row_valid on index 2^N_IN-1.
REQ-019 busy  out  1  high in SWEEP state.
REQ-020 done  out  1  one-cycle pulse after the last row is accepted.

Function
REQ-021 Table storage SHALL be 2^N_IN rows x N_OUT bits, held in flops.
REQ-022 Write: wr_en high in IDLE or DONE SHALL set table[wr_addr]=wr_data at the clock edge; new data is visible from the next cycle.
REQ-023 wr_en high in SWEEP SHALL leave the table unchanged and pulse wr_err for exactly one cycle.
REQ-024 Eval: eval_en in cycle T SHALL give eval_out=table[eval_in] and eval_valid=1 in cycle T+1; eval_valid=0 in cycles with no request in the previous cycle. Eval operates in every state.
REQ-025 Eval and write to the same address in the same cycle SHALL return the pre-write data.
REQ-026 eval_out SHALL hold its last value while eval_valid=0.
REQ-027 FSM states: IDLE, SWEEP, DONE.
REQ-028 IDLE: sweep_start=1 -> SWEEP, with the index counter set to 0.
REQ-029 SWEEP: row_valid=1, row_idx=counter, row_out=table[counter], row_last=(counter==2^N_IN-1).
REQ-030 Handshake: a row transfers on a cycle with row_valid&row_ready. Without a transfer, row_idx, row_out and row_last SHALL stay stable.
REQ-031 On a transfer with counter<2^N_IN-1, the counter SHALL increment by 1. On a transfer with counter==2^N_IN-1, the FSM SHALL go to DONE and the counter SHALL wrap to 0.
REQ-032 DONE lasts exactly one cycle with done=1, then returns to IDLE. A sweep_start in DONE is ignored.
REQ-033 sweep_start in SWEEP SHALL be ignored; it does not restart the sweep.
REQ-034 row_valid, busy and done SHALL be 0 outside SWEEP and DONE respectively; busy=1 only in SWEEP.
REQ-035 Back-to-back transfers with row_ready held high SHALL stream one row per cycle. A full sweep then takes 2^N_IN cycles in SWEEP.

Reset
REQ-036 rst=1 SHALL immediately force: FSM to IDLE, counter to 0, all table rows to 0, eval_out=0, and eval_valid, row_valid, row_idx, row_out, row_last, busy, done and wr_err all to 0.
REQ-037 Reset mid-sweep SHALL abort the sweep with no done pulse. After rst falls, the block idles until the next sweep_start.

Verification
REQ-038 Reset then immediate sweep with row_ready=1 -> 16 rows, idx 0..15, all row_out=0, row_last only on idx 15, done one cycle after the idx-15 transfer.
REQ-039 Write row 5=6'b101101 and row 10=6'b010011, then eval 5, 10, 3 on consecutive cycles -> eval_out 101101, 010011, 000000, each one cycle later with eval_valid=1.
REQ-040 Sweep with row_ready toggling 1,0,0,1... -> no row skipped or duplicated, outputs stable during stalls, 16 transfers total.
REQ-041 wr_en at row 7 during SWEEP -> wr_err pulses once; a later eval of 7 returns the old value; the sweep completes normally.
REQ-042 rst asserted while row_idx=9 -> all outputs 0 asynchronously, no done pulse, table reads 0 afterwards.
REQ-043 N_IN=2, N_OUT=3 build, write all 4 rows, sweep -> 4 rows with the written data, row_last on idx 3, counter wraps to 0.
